// File: rtl/mempool_bank_arbiter.sv
// Round-robin arbiter sharing one TCDM bank; AMOs run as bank read then locked write-back.
// Latency: response 1 cycle after grant; backpressure: no grant while an AMO write-back owns the bank.
module mempool_bank_arbiter #(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned BankAddrWidth = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  logic [NumReq*32-1:0]       req_addr_i,
    input  logic [NumReq-1:0]          req_wen_i,
    input  logic [NumReq*32-1:0]       req_wdata_i,
    input  logic [NumReq*4-1:0]        req_be_i,
    input  logic [NumReq*4-1:0]        req_amo_i,
    output logic [NumReq-1:0]          resp_valid_o,
    output logic [31:0]                resp_rdata_o,
    output logic                       bank_req_o,
    output logic                       bank_we_o,
    output logic [BankAddrWidth-1:0]   bank_addr_o,
    output logic [31:0]                bank_wdata_o,
    output logic [3:0]                 bank_be_o,
    input  logic [31:0]                bank_rdata_i
);
    localparam int unsigned ByteOffset = 2;
    localparam int unsigned PtrW       = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [3:0]  amo_t;
    typedef logic [BankAddrWidth-1:0] waddr_t;

    localparam amo_t AmoSwap = 4'd1;
    localparam amo_t AmoAdd  = 4'd2;
    localparam amo_t AmoAnd  = 4'd3;
    localparam amo_t AmoOr   = 4'd4;
    localparam amo_t AmoXor  = 4'd5;
    localparam amo_t AmoMax  = 4'd6;
    localparam amo_t AmoMaxu = 4'd7;
    localparam amo_t AmoMin  = 4'd8;
    localparam amo_t AmoMinu = 4'd9;

    typedef struct packed {
        amo_t   op;
        data_t  operand;
        waddr_t addr;
    } amo_state_t;

    typedef enum logic {IDLE, AMO_WB} state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q;
    amo_state_t        amo_q;
    logic [NumReq-1:0] resp_vld_q;
    logic              resp_rd_q;

    logic              gnt_vld;
    logic [PtrW-1:0]   gnt_idx;
    logic [PtrW-1:0]   cand;
    int unsigned       idx;
    waddr_t            sel_waddr;
    data_t             sel_wdata;
    strb_t             sel_be;
    amo_t              sel_amo;
    logic              sel_wen;
    logic              sel_is_amo;
    logic              grant_fire;
    data_t             amo_result;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx  = (32'(ptr_q) + k) % NumReq;
            cand = PtrW'(idx);
            if (!gnt_vld && req_valid_i[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign sel_waddr  = req_addr_i[gnt_idx*32 + ByteOffset +: BankAddrWidth];
    assign sel_wdata  = req_wdata_i[gnt_idx*32 +: 32];
    assign sel_be     = req_be_i[gnt_idx*4 +: 4];
    assign sel_amo    = req_amo_i[gnt_idx*4 +: 4];
    assign sel_wen    = req_wen_i[gnt_idx];
    assign sel_is_amo = (sel_amo >= AmoSwap) && (sel_amo <= AmoMinu);
    assign grant_fire = (state_q == IDLE) && gnt_vld;

    always_comb begin
        amo_result = amo_q.operand;
        case (amo_q.op)
            AmoAdd:  amo_result = bank_rdata_i + amo_q.operand;
            AmoAnd:  amo_result = bank_rdata_i & amo_q.operand;
            AmoOr:   amo_result = bank_rdata_i | amo_q.operand;
            AmoXor:  amo_result = bank_rdata_i ^ amo_q.operand;
            AmoMax:  amo_result = ($signed(bank_rdata_i) > $signed(amo_q.operand)) ? bank_rdata_i : amo_q.operand;
            AmoMaxu: amo_result = (bank_rdata_i > amo_q.operand) ? bank_rdata_i : amo_q.operand;
            AmoMin:  amo_result = ($signed(bank_rdata_i) < $signed(amo_q.operand)) ? bank_rdata_i : amo_q.operand;
            AmoMinu: amo_result = (bank_rdata_i < amo_q.operand) ? bank_rdata_i : amo_q.operand;
            default: amo_result = amo_q.operand;
        endcase
    end

    // Outputs are forced quiet while reset is held so an abandoned write-back never reaches the bank.
    always_comb begin
        state_d      = state_q;
        req_ready_o  = '0;
        bank_req_o   = 1'b0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        req_ready_o[gnt_idx] = 1'b1;
                        bank_req_o           = 1'b1;
                        bank_addr_o          = sel_waddr;
                        if (sel_is_amo) begin
                            bank_be_o = 4'hF;
                            state_d   = AMO_WB;
                        end else begin
                            bank_we_o    = sel_wen;
                            bank_wdata_o = sel_wdata;
                            bank_be_o    = sel_be;
                        end
                    end
                end
                AMO_WB: begin
                    bank_req_o   = 1'b1;
                    bank_we_o    = 1'b1;
                    bank_addr_o  = amo_q.addr;
                    bank_wdata_o = amo_result;
                    bank_be_o    = 4'hF;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            amo_q      <= '0;
            resp_vld_q <= '0;
            resp_rd_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            resp_vld_q <= req_ready_o;
            if (grant_fire) begin
                ptr_q     <= (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
                resp_rd_q <= sel_is_amo || !sel_wen;
                if (sel_is_amo) begin
                    amo_q <= '{op: sel_amo, operand: sel_wdata, addr: sel_waddr};
                end
            end
        end
    end

    assign resp_valid_o = rst_i ? '0 : resp_vld_q;
    assign resp_rdata_o = (!rst_i && (|resp_vld_q) && resp_rd_q) ? bank_rdata_i : '0;
endmodule

// File: tb/tb_mempool_bank_arbiter.sv
// Directed bench for mempool_bank_arbiter with a behavioural single-port bank model.
module tb_mempool_bank_arbiter;
    localparam int NumReq = 4;
    localparam int AW     = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NumReq-1:0]     req_valid;
    logic [NumReq-1:0]     req_ready;
    logic [NumReq*32-1:0]  req_addr;
    logic [NumReq-1:0]     req_wen;
    logic [NumReq*32-1:0]  req_wdata;
    logic [NumReq*4-1:0]   req_be;
    logic [NumReq*4-1:0]   req_amo;
    logic [NumReq-1:0]     resp_valid;
    logic [31:0]           resp_rdata;
    logic                  bank_req;
    logic                  bank_we;
    logic [AW-1:0]         bank_addr;
    logic [31:0]           bank_wdata;
    logic [3:0]            bank_be;
    logic [31:0]           bank_rdata;

    logic [31:0] mem [0:(1<<AW)-1];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mempool_bank_arbiter #(.NumReq(NumReq), .BankAddrWidth(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_wen_i(req_wen), .req_wdata_i(req_wdata),
        .req_be_i(req_be), .req_amo_i(req_amo),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
        .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
    );

    // Bank macro: read data registered, byte-enabled writes.
    always @(posedge clk) begin
        if (bank_req) begin
            if (bank_we) begin
                for (int b = 0; b < 4; b++)
                    if (bank_be[b]) mem[bank_addr][b*8 +: 8] <= bank_wdata[b*8 +: 8];
            end else begin
                bank_rdata <= mem[bank_addr];
            end
        end
    end

    typedef struct {
        int          r;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  amo;
        logic [31:0] exp_rdata;
        logic        exp_wb;
        logic [31:0] exp_wbdata;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_addr = '0; req_wen = '0;
        req_wdata = '0; req_be = '0; req_amo = '0;
    endtask

    task automatic drive(input int r, input logic [31:0] addr, input logic wen,
                         input logic [31:0] wdata, input logic [3:0] be, input logic [3:0] amo);
        req_valid[r]          = 1'b1;
        req_addr[r*32 +: 32]  = addr;
        req_wen[r]            = wen;
        req_wdata[r*32 +: 32] = wdata;
        req_be[r*4 +: 4]      = be;
        req_amo[r*4 +: 4]     = amo;
    endtask

    task automatic do_vec(input vec_t v);
        logic is_amo;
        logic [AW-1:0] waddr;
        is_amo = (v.amo >= 4'd1) && (v.amo <= 4'd9);
        waddr  = v.addr[AW+1:2];
        @(negedge clk);
        clear_reqs();
        drive(v.r, v.addr, v.wen, v.wdata, v.be, v.amo);
        #1;
        check("grant", 32'(req_ready), 32'(1) << v.r);
        check("bank_req", 32'(bank_req), 32'd1);
        check("bank_we", 32'(bank_we), is_amo ? 32'd0 : 32'(v.wen));
        check("bank_addr", 32'(bank_addr), 32'(waddr));
        if (!is_amo && v.wen) begin
            check("bank_wdata", bank_wdata, v.wdata);
            check("bank_be", 32'(bank_be), 32'(v.be));
        end
        @(negedge clk);
        clear_reqs();
        #1;
        check("resp_valid", 32'(resp_valid), 32'(1) << v.r);
        check("resp_rdata", resp_rdata, v.exp_rdata);
        if (v.exp_wb) begin
            check("wb_req", 32'({bank_req, bank_we}), 32'h3);
            check("wb_be", 32'(bank_be), 32'hF);
            check("wb_addr", 32'(bank_addr), 32'(waddr));
            check("wb_data", bank_wdata, v.exp_wbdata);
            check("wb_ready", 32'(req_ready), 32'd0);
        end else begin
            check("idle_bank_req", 32'(bank_req), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        bank_rdata = '0;
        //           r  addr           wen wdata          be    amo  rdata          wb  wbdata
        vecs[0]  = '{0, 32'h10,        1, 32'hDEADBEEF, 4'hF, 4'd0, 32'h0,        0, 32'h0};
        vecs[1]  = '{1, 32'h10,        0, 32'h0,        4'hF, 4'd0, 32'hDEADBEEF, 0, 32'h0};
        vecs[2]  = '{3, 32'h14,        1, 32'h11223344, 4'h5, 4'd0, 32'h0,        0, 32'h0};
        vecs[3]  = '{2, 32'h14,        0, 32'h0,        4'hF, 4'd0, 32'h00220044, 0, 32'h0};
        vecs[4]  = '{2, 32'h20,        1, 32'h5,        4'hF, 4'd0, 32'h0,        0, 32'h0};
        vecs[5]  = '{2, 32'h20,        0, 32'h3,        4'h0, 4'd2, 32'h5,        1, 32'h8};
        vecs[6]  = '{0, 32'h20,        0, 32'h0,        4'hF, 4'd0, 32'h8,        0, 32'h0};
        vecs[7]  = '{1, 32'h30,        1, 32'hFFFFFFFF, 4'hF, 4'd0, 32'h0,        0, 32'h0};
        vecs[8]  = '{1, 32'h30,        1, 32'h1,        4'h0, 4'd8, 32'hFFFFFFFF, 1, 32'hFFFFFFFF};
        vecs[9]  = '{1, 32'h30,        0, 32'h1,        4'h3, 4'd9, 32'hFFFFFFFF, 1, 32'h1};
        vecs[10] = '{3, 32'h30,        0, 32'h0,        4'hF, 4'd0, 32'h1,        0, 32'h0};
        vecs[11] = '{0, 32'h30,        0, 32'hCAFEF00D, 4'h0, 4'd1, 32'h1,        1, 32'hCAFEF00D};
        vecs[12] = '{0, 32'h30,        0, 32'h80000000, 4'h0, 4'd6, 32'hCAFEF00D, 1, 32'hCAFEF00D};
        vecs[13] = '{3, 32'h30,        0, 32'hF0000000, 4'h0, 4'd7, 32'hCAFEF00D, 1, 32'hF0000000};
        vecs[14] = '{2, 32'h30,        0, 32'h0F0F0F0F, 4'h0, 4'd3, 32'hF0000000, 1, 32'h0};
        vecs[15] = '{1, 32'h30,        0, 32'h12345678, 4'h0, 4'd4, 32'h0,        1, 32'h12345678};
        vecs[16] = '{0, 32'h30,        0, 32'hFFFF0000, 4'h0, 4'd5, 32'h12345678, 1, 32'hEDCB5678};
        vecs[17] = '{3, 32'h30,        0, 32'h0,        4'hF, 4'd12, 32'hEDCB5678, 0, 32'h0};
        vecs[18] = '{2, 32'hFFFFF030,  0, 32'h0,        4'hF, 4'd0, 32'hEDCB5678, 0, 32'h0};

        // Reset: outputs quiet even with every requester asking.
        clear_reqs();
        rst = 1'b1;
        req_valid = '1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_bank", 32'({bank_req, bank_we, bank_be}), 32'd0);
        check("rst_bank_wdata", bank_wdata, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();

        for (int i = 0; i < 19; i++) do_vec(vecs[i]);

        // Fairness after a fresh reset: pointer restarts at 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        for (int r = 0; r < NumReq; r++) drive(r, 32'h10, 1'b0, 32'h0, 4'hF, 4'd0);
        for (int c = 0; c < 8; c++) begin
            #1;
            check("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (c > 0) begin
                check("rr_resp_valid", 32'(resp_valid), 32'(1) << ((c - 1) % 4));
                check("rr_resp_rdata", resp_rdata, 32'hDEADBEEF);
            end
            @(negedge clk);
        end

        // Contention: AMO on req0 locks the bank for one cycle, req1 waits until T+2.
        clear_reqs();
        drive(0, 32'h40, 1'b0, 32'h1, 4'h0, 4'd2);
        drive(1, 32'h40, 1'b0, 32'h0, 4'hF, 4'd0);
        #1;
        check("cont_t0_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        check("cont_t1_grant", 32'(req_ready), 32'h0);
        check("cont_t1_resp", 32'(resp_valid), 32'h1);
        check("cont_t1_old", resp_rdata, 32'h0);
        check("cont_t1_wb", bank_wdata, 32'h1);
        @(negedge clk);
        #1;
        check("cont_t2_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        clear_reqs();
        #1;
        check("cont_t3_resp", 32'(resp_valid), 32'h2);
        check("cont_t3_new", resp_rdata, 32'h1);

        // Reset landing in AMO write-back abandons the write and rewinds the pointer.
        do_vec('{2, 32'h50, 1, 32'h77, 4'hF, 4'd0, 32'h0, 0, 32'h0});
        @(negedge clk);
        clear_reqs();
        drive(0, 32'h50, 1'b0, 32'h1, 4'h0, 4'd2);
        #1;
        check("rmid_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmid_ready", 32'(req_ready), 32'h0);
        check("rmid_bank", 32'({bank_req, bank_we}), 32'h0);
        check("rmid_resp_valid", 32'(resp_valid), 32'h0);
        check("rmid_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_reqs();
        drive(0, 32'h50, 1'b0, 32'h0, 4'hF, 4'd0);
        drive(1, 32'h50, 1'b0, 32'h0, 4'hF, 4'd0);
        #1;
        check("rmid_ptr0", 32'(req_ready), 32'h1);
        @(negedge clk);
        clear_reqs();
        #1;
        check("rmid_resp", 32'(resp_valid), 32'h1);
        check("rmid_keep", resp_rdata, 32'h77);
        check("rmid_mem", mem[32'h50 >> 2], 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
